// File: rtl/blit_engine_pkg.sv
// Shared opcodes, framebuffer geometry and FSM states for the blitter.
// Also holds the column clip test used when walking window bytes.
package blit_engine_pkg;

  localparam logic [2:0] BLIT_OP_NONE      = 3'd0;
  localparam logic [2:0] BLIT_OP_CLEAR     = 3'd1;
  localparam logic [2:0] BLIT_OP_SPRITE    = 3'd2;
  localparam logic [2:0] BLIT_OP_SPRITE_16 = 3'd3;

  localparam int FB_STRIDE = 16;
  localparam int FB_SIZE   = 1024;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SRC_RD,
    S_SRC_WAIT,
    S_SRC_CAP,
    S_FB_RD,
    S_FB_WAIT,
    S_FB_CAP,
    S_FB_WR,
    S_ROW_NEXT,
    S_CLR_WR,
    S_DONE
  } state_t;

  function automatic logic col_clip(
    input logic [6:0] x0,
    input logic [1:0] k,
    input logic       hi
  );
    logic [4:0] col;
    col = {1'b0, x0[6:3]} + {3'b0, k};
    return hi ? (col >= 5'd16) : (col >= 5'd8);
  endfunction

endpackage

// File: rtl/blit_engine_row_align.sv
// Shifts a sprite row into its framebuffer byte window.
// Caller zeroes b1 for 8-wide sprites.
module blit_row_align (
  input  logic [7:0]  i_b0,
  input  logic [7:0]  i_b1,
  input  logic [2:0]  i_shift,
  output logic [23:0] o_win
);

  logic [23:0] w_cat;

  assign w_cat = {i_b0, i_b1, 8'h00};
  assign o_win = w_cat >> i_shift;

endmodule

// File: rtl/blit_engine.sv
// Framebuffer blitter: CLEAR, SPRITE and SPRITE_16 with XOR draw,
// clipping and collision, over two synchronous RAM read ports.
module blit_engine
  import blit_engine_pkg::*;
#(
  parameter int FB_ADDR_W  = 10,
  parameter int SRC_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hires,
  input  logic [2:0]            blit_op,
  input  logic [11:0]           blit_src,
  input  logic [3:0]            blit_srcHeight,
  input  logic [6:0]            blit_destX,
  input  logic [5:0]            blit_destY,
  input  logic                  blit_enable,
  output logic                  blit_done,
  output logic                  blit_collision,
  output logic                  busy,
  output logic                  src_en,
  output logic [SRC_ADDR_W-1:0] src_addr,
  input  logic [7:0]            src_rdata,
  output logic                  fb_en,
  output logic                  fb_wr,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [7:0]            fb_wdata,
  input  logic [7:0]            fb_rdata
);

  state_t                r_state;
  logic                  r_en_q;
  logic                  r_done;
  logic                  r_coll;
  logic                  r_busy;
  logic                  r_src_en;
  logic [SRC_ADDR_W-1:0] r_src_addr;
  logic                  r_fb_en;
  logic                  r_fb_wr;
  logic [FB_ADDR_W-1:0]  r_fb_addr;
  logic [7:0]            r_fb_wdata;
  logic                  r_wide;
  logic                  r_hires;
  logic [11:0]           r_src;
  logic [4:0]            r_rows;
  logic [4:0]            r_row;
  logic [6:0]            r_x0;
  logic [5:0]            r_y0;
  logic                  r_sb;
  logic [1:0]            r_wb;
  logic [7:0]            r_b0;
  logic [7:0]            r_b1;

  logic                  w_start;
  logic                  w_is_clr;
  logic                  w_is_spr;
  logic [23:0]           w_win;
  logic [7:0]            w_winb;
  logic [7:0]            w_b1;
  logic [6:0]            w_y;
  logic [4:0]            w_row_nx;
  logic [6:0]            w_y_nx;
  logic [6:0]            w_ylim;
  logic [1:0]            w_wb_nx;
  logic                  w_last_wb;
  logic                  w_clip_cur;
  logic                  w_nx_clip;
  logic [FB_ADDR_W-1:0]  w_nx_addr;
  logic [FB_ADDR_W-1:0]  w_first_addr;

  function automatic logic [FB_ADDR_W-1:0] fb_addr_of(
    input logic [6:0] y,
    input logic [6:0] x0,
    input logic [1:0] k
  );
    logic [4:0] col;
    col = {1'b0, x0[6:3]} + {3'b0, k};
    return FB_ADDR_W'(32'(y) * FB_STRIDE + 32'(col));
  endfunction

  function automatic logic [SRC_ADDR_W-1:0] src_addr_of(
    input logic [4:0] row,
    input logic       sb
  );
    logic [11:0] off;
    off = r_wide ? {6'd0, row, sb} : {7'd0, row};
    return SRC_ADDR_W'(r_src + off);
  endfunction

  assign w_start  = blit_enable & ~r_en_q;
  assign w_is_clr = (blit_op == BLIT_OP_CLEAR);
  assign w_is_spr = (blit_op == BLIT_OP_SPRITE && blit_srcHeight != 4'd0)
                  || (blit_op == BLIT_OP_SPRITE_16);

  assign w_b1 = r_wide ? r_b1 : 8'h00;

  blit_row_align u_align (
    .i_b0    (r_b0),
    .i_b1    (w_b1),
    .i_shift (r_x0[2:0]),
    .o_win   (w_win)
  );

  always_comb begin
    w_winb = w_win[7:0];
    unique case (r_wb)
      2'd0:    w_winb = w_win[23:16];
      2'd1:    w_winb = w_win[15:8];
      default: w_winb = w_win[7:0];
    endcase
  end

  assign w_y          = {1'b0, r_y0} + {2'b0, r_row};
  assign w_row_nx     = r_row + 5'd1;
  assign w_y_nx       = {1'b0, r_y0} + {2'b0, w_row_nx};
  assign w_ylim       = r_hires ? 7'd64 : 7'd32;
  assign w_wb_nx      = r_wb + 2'd1;
  assign w_last_wb    = r_wide ? (r_wb == 2'd2) : (r_wb == 2'd1);
  assign w_clip_cur   = col_clip(r_x0, r_wb, r_hires);
  assign w_nx_clip    = col_clip(r_x0, w_wb_nx, r_hires);
  assign w_nx_addr    = fb_addr_of(w_y, r_x0, w_wb_nx);
  assign w_first_addr = fb_addr_of(w_y, r_x0, 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_en_q     <= 1'b0;
      r_done     <= 1'b0;
      r_coll     <= 1'b0;
      r_busy     <= 1'b0;
      r_src_en   <= 1'b0;
      r_src_addr <= '0;
      r_fb_en    <= 1'b0;
      r_fb_wr    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= 8'h00;
      r_wide     <= 1'b0;
      r_hires    <= 1'b0;
      r_src      <= 12'h000;
      r_rows     <= 5'd0;
      r_row      <= 5'd0;
      r_x0       <= 7'd0;
      r_y0       <= 6'd0;
      r_sb       <= 1'b0;
      r_wb       <= 2'd0;
      r_b0       <= 8'h00;
      r_b1       <= 8'h00;
    end else begin
      r_en_q <= blit_enable;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_busy  <= 1'b1;
            r_coll  <= 1'b0;
            r_hires <= hires;
            r_src   <= blit_src;
            r_wide  <= (blit_op == BLIT_OP_SPRITE_16);
            r_rows  <= (blit_op == BLIT_OP_SPRITE_16) ? 5'd16
                       : {1'b0, blit_srcHeight};
            r_x0    <= hires ? blit_destX : {1'b0, blit_destX[5:0]};
            r_y0    <= hires ? blit_destY : {1'b0, blit_destY[4:0]};
            r_row   <= 5'd0;
            r_sb    <= 1'b0;
            r_wb    <= 2'd0;
            unique case (1'b1)
              w_is_clr: begin
                r_state    <= S_CLR_WR;
                r_fb_en    <= 1'b1;
                r_fb_wr    <= 1'b1;
                r_fb_addr  <= '0;
                r_fb_wdata <= 8'h00;
              end
              w_is_spr: begin
                r_state    <= S_SRC_RD;
                r_src_en   <= 1'b1;
                r_src_addr <= SRC_ADDR_W'(blit_src);
              end
              default: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        S_SRC_RD:   r_state <= S_SRC_WAIT;
        S_SRC_WAIT: r_state <= S_SRC_CAP;
        S_SRC_CAP: begin
          if (r_sb) r_b1 <= src_rdata;
          else      r_b0 <= src_rdata;
          if (r_wide && !r_sb) begin
            r_sb       <= 1'b1;
            r_src_addr <= src_addr_of(r_row, 1'b1);
            r_state    <= S_SRC_RD;
          end else begin
            r_src_en  <= 1'b0;
            r_wb      <= 2'd0;
            r_fb_en   <= ~col_clip(r_x0, 2'd0, r_hires);
            r_fb_addr <= w_first_addr;
            r_state   <= S_FB_RD;
          end
        end
        S_FB_RD: begin
          if (!w_clip_cur) begin
            r_state <= S_FB_WAIT;
          end else if (w_last_wb) begin
            r_fb_en <= 1'b0;
            r_state <= S_ROW_NEXT;
          end else begin
            r_wb      <= w_wb_nx;
            r_fb_en   <= ~w_nx_clip;
            r_fb_addr <= w_nx_addr;
          end
        end
        S_FB_WAIT: r_state <= S_FB_CAP;
        S_FB_CAP: begin
          r_fb_wr    <= 1'b1;
          r_fb_wdata <= fb_rdata ^ w_winb;
          if ((fb_rdata & w_winb) != 8'h00) r_coll <= 1'b1;
          r_state    <= S_FB_WR;
        end
        S_FB_WR: begin
          r_fb_wr <= 1'b0;
          if (w_last_wb) begin
            r_fb_en <= 1'b0;
            r_state <= S_ROW_NEXT;
          end else begin
            r_wb      <= w_wb_nx;
            r_fb_en   <= ~w_nx_clip;
            r_fb_addr <= w_nx_addr;
            r_state   <= S_FB_RD;
          end
        end
        S_ROW_NEXT: begin
          if (w_row_nx == r_rows) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row <= w_row_nx;
            r_sb  <= 1'b0;
            // Rows past the bottom edge burn one cycle each here.
            if (w_y_nx < w_ylim) begin
              r_src_en   <= 1'b1;
              r_src_addr <= src_addr_of(w_row_nx, 1'b0);
              r_state    <= S_SRC_RD;
            end
          end
        end
        S_CLR_WR: begin
          if (r_fb_addr == FB_ADDR_W'(FB_SIZE - 1)) begin
            r_fb_en <= 1'b0;
            r_fb_wr <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_fb_addr <= r_fb_addr + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign blit_done      = r_done;
  assign blit_collision = r_coll;
  assign busy           = r_busy;
  assign src_en         = r_src_en;
  assign src_addr       = r_src_addr;
  assign fb_en          = r_fb_en;
  assign fb_wr          = r_fb_wr;
  assign fb_addr        = r_fb_addr;
  assign fb_wdata       = r_fb_wdata;

endmodule

// File: tb/tb_blit_engine.sv
// Bench for blit_engine: RAM models, pixel-level reference model,
// write scoreboard, vector table and multi-cycle corner sequences.
module tb_blit_engine;
  import blit_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hires = 1'b0;
  logic [2:0]  blit_op = 3'd0;
  logic [11:0] blit_src = 12'h0;
  logic [3:0]  blit_srcHeight = 4'd0;
  logic [6:0]  blit_destX = 7'd0;
  logic [5:0]  blit_destY = 6'd0;
  logic        blit_enable = 1'b0;
  logic        blit_done;
  logic        blit_collision;
  logic        busy;
  logic        src_en;
  logic [11:0] src_addr;
  logic [7:0]  src_rdata = 8'h00;
  logic        fb_en;
  logic        fb_wr;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_wdata;
  logic [7:0]  fb_rdata = 8'h00;

  always #5 clk = ~clk;

  blit_engine #(.FB_ADDR_W(10), .SRC_ADDR_W(12)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hires          (hires),
    .blit_op        (blit_op),
    .blit_src       (blit_src),
    .blit_srcHeight (blit_srcHeight),
    .blit_destX     (blit_destX),
    .blit_destY     (blit_destY),
    .blit_enable    (blit_enable),
    .blit_done      (blit_done),
    .blit_collision (blit_collision),
    .busy           (busy),
    .src_en         (src_en),
    .src_addr       (src_addr),
    .src_rdata      (src_rdata),
    .fb_en          (fb_en),
    .fb_wr          (fb_wr),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata),
    .fb_rdata       (fb_rdata)
  );

  logic [7:0] fb_mem  [1024];
  logic [7:0] src_mem [4096];
  logic [7:0] exp_fb  [1024];
  logic       preset = 1'b0;

  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 1024; i++) fb_mem[i] = 8'hFF;
    end else if (fb_en) begin
      fb_rdata <= fb_mem[fb_addr];
      if (fb_wr) fb_mem[fb_addr] = fb_wdata;
    end
    if (src_en) src_rdata <= src_mem[src_addr];
  end

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [2:0]  op;
    logic        hi;
    logic [11:0] src;
    logic [3:0]  h;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        coll;
    int          cyc;
  } vec_t;

  wr_t  wq[$];
  vec_t tbl[11];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (blit_done) done_cnt++;
      if (rst_n && fb_en && fb_wr) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected addr %0d data %02h required none",
                   fb_addr, fb_wdata);
        end else begin
          e = wq.pop_front();
          if (fb_addr !== e.a || fb_wdata !== e.d) begin
            errors++;
            $display("FAIL wr got addr %0d data %02h required addr %0d data %02h",
                     fb_addr, fb_wdata, e.a, e.d);
          end
        end
      end
    end
  endtask

  // Pixel-level reference: toggles pixels, then queues the touched bytes.
  task automatic push_op(input vec_t v, input int lim, output logic c);
    int W, H, x0, y0, nr, nb, ncol, py, px, a, col, s;
    logic [15:0] bits;
    logic [7:0] m;
    logic wide;
    wr_t e;
    c = 1'b0;
    W = v.hi ? 128 : 64;
    H = v.hi ? 64 : 32;
    x0 = int'(v.x) % W;
    y0 = int'(v.y) % H;
    wide = (v.op == BLIT_OP_SPRITE_16);
    s = int'(v.src);
    if (v.op == BLIT_OP_CLEAR) begin
      for (int i = 0; i < 1024; i++) begin
        exp_fb[i] = 8'h00;
        e.a = 10'(i);
        e.d = 8'h00;
        wq.push_back(e);
      end
    end else if ((v.op == BLIT_OP_SPRITE && v.h != 4'd0) || wide) begin
      nr = wide ? 16 : int'(v.h);
      nb = wide ? 16 : 8;
      ncol = wide ? 3 : 2;
      for (int r = 0; r < nr && r < lim; r++) begin
        py = y0 + r;
        if (py < H) begin
          if (wide)
            bits = {src_mem[(s + 2*r) % 4096], src_mem[(s + 2*r + 1) % 4096]};
          else
            bits = {src_mem[(s + r) % 4096], 8'h00};
          for (int c2 = 0; c2 < nb; c2++) begin
            px = x0 + c2;
            if (bits[15 - c2] && px < W) begin
              a = py * 16 + px / 8;
              m = 8'h80 >> (px % 8);
              if ((exp_fb[a] & m) != 8'h00) c = 1'b1;
              exp_fb[a] = exp_fb[a] ^ m;
            end
          end
          for (int k = 0; k < ncol; k++) begin
            col = x0 / 8 + k;
            if (col < W / 8) begin
              e.a = 10'(py * 16 + col);
              e.d = exp_fb[py * 16 + col];
              wq.push_back(e);
            end
          end
        end
      end
    end
  endtask

  task automatic fb_cmp(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (fb_mem[i] !== exp_fb[i]) bad++;
    chk({nm, " fb_bad_bytes"}, bad, 0);
  endtask

  task automatic drive(input vec_t v);
    hires = v.hi;
    blit_op = v.op;
    blit_src = v.src;
    blit_srcHeight = v.h;
    blit_destX = v.x;
    blit_destY = v.y;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic mc;
    int n;
    bit got;
    push_op(v, 99, mc);
    @(negedge clk);
    drive(v);
    blit_enable = 1'b1;
    n = 1;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (blit_done) got = 1'b1;
    end
    chk({nm, " done_seen"}, int'(got), 1);
    chk({nm, " cycles"}, n, v.cyc);
    chk({nm, " collision"}, int'(blit_collision), int'(v.coll));
    chk({nm, " busy_at_done"}, int'(busy), 1);
    @(negedge clk);
    blit_enable = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " done_one_cycle"}, int'(blit_done), 0);
    chk({nm, " busy_after"}, int'(busy), 0);
    chk({nm, " coll_hold"}, int'(blit_collision), int'(v.coll));
    chk({nm, " pending_writes"}, wq.size(), 0);
    fb_cmp(nm);
  endtask

  initial begin
    vec_t v;
    logic mc;
    int d0, n;

    //        op                 hi src     h     x      y     coll  cyc
    tbl[0]  = '{BLIT_OP_CLEAR,     0, 12'h000, 4'd0, 7'd0,   6'd0,  0, 1026};
    tbl[1]  = '{BLIT_OP_SPRITE,    0, 12'h100, 4'd1, 7'd3,   6'd0,  0, 14};
    tbl[2]  = '{BLIT_OP_SPRITE,    0, 12'h100, 4'd1, 7'd3,   6'd0,  1, 14};
    tbl[3]  = '{BLIT_OP_SPRITE,    0, 12'h110, 4'd1, 7'd70,  6'd33, 0, 14};
    tbl[4]  = '{BLIT_OP_SPRITE_16, 1, 12'h200, 4'd0, 7'd124, 6'd60, 0, 66};
    tbl[5]  = '{BLIT_OP_SPRITE_16, 1, 12'h200, 4'd0, 7'd0,   6'd0,  1, 306};
    tbl[6]  = '{BLIT_OP_SPRITE,    0, 12'h100, 4'd0, 7'd5,   6'd5,  0, 2};
    tbl[7]  = '{BLIT_OP_NONE,      0, 12'h100, 4'd3, 7'd5,   6'd5,  0, 2};
    tbl[8]  = '{3'd5,              1, 12'h100, 4'd3, 7'd5,   6'd5,  0, 2};
    tbl[9]  = '{BLIT_OP_SPRITE,    1, 12'h120, 4'd3, 7'd121, 6'd10, 0, 29};
    tbl[10] = '{BLIT_OP_SPRITE,    0, 12'h130, 4'd4, 7'd60,  6'd30, 0, 22};

    for (int i = 0; i < 4096; i++) src_mem[i] = 8'h00;
    src_mem[12'h100] = 8'hF0;
    src_mem[12'h110] = 8'h80;
    for (int i = 0; i < 32; i++) src_mem[12'h200 + i] = 8'hFF;
    src_mem[12'h120] = 8'hAA;
    src_mem[12'h121] = 8'h55;
    src_mem[12'h122] = 8'hC3;
    for (int i = 0; i < 4; i++) src_mem[12'h130 + i] = 8'hFF;
    src_mem[12'h140] = 8'h3C;
    src_mem[12'h150] = 8'h81;
    src_mem[12'h151] = 8'h42;
    src_mem[12'h152] = 8'h24;
    src_mem[12'h153] = 8'h18;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst blit_done", int'(blit_done), 0);
    chk("rst collision", int'(blit_collision), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst src_en", int'(src_en), 0);
    chk("rst src_addr", int'(src_addr), 0);
    chk("rst fb_en", int'(fb_en), 0);
    chk("rst fb_wr", int'(fb_wr), 0);
    chk("rst fb_addr", int'(fb_addr), 0);
    chk("rst fb_wdata", int'(fb_wdata), 0);

    preset = 1'b1;
    for (int i = 0; i < 1024; i++) exp_fb[i] = 8'hFF;
    @(negedge clk);
    preset = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Enable held high across a whole operation.
    v = '{BLIT_OP_SPRITE, 0, 12'h140, 4'd1, 7'd8, 6'd2, 0, 14};
    push_op(v, 99, mc);
    @(negedge clk);
    drive(v);
    d0 = done_cnt;
    blit_enable = 1'b1;
    repeat (400) @(negedge clk);
    chk("hold done_pulses", done_cnt - d0, 1);
    blit_enable = 1'b0;
    chk("hold pending_writes", wq.size(), 0);
    fb_cmp("hold");

    // Second rising edge while busy.
    v = '{BLIT_OP_SPRITE_16, 1, 12'h200, 4'd0, 7'd32, 6'd16, 0, 306};
    push_op(v, 99, mc);
    @(negedge clk);
    drive(v);
    d0 = done_cnt;
    blit_enable = 1'b1;
    repeat (20) @(negedge clk);
    blit_enable = 1'b0;
    repeat (2) @(negedge clk);
    blit_enable = 1'b1;
    repeat (600) @(negedge clk);
    chk("reedge done_pulses", done_cnt - d0, 1);
    blit_enable = 1'b0;
    chk("reedge pending_writes", wq.size(), 0);
    fb_cmp("reedge");

    // Reset during FB_WAIT of row 2: only rows 0 and 1 land.
    v = '{BLIT_OP_SPRITE, 0, 12'h150, 4'd4, 7'd16, 6'd4, 0, 50};
    push_op(v, 2, mc);
    @(negedge clk);
    drive(v);
    blit_enable = 1'b1;
    n = 1;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort fb_en_before", int'(fb_en), 1);
    chk("abort busy_before", int'(busy), 1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort fb_en", int'(fb_en), 0);
    chk("abort fb_wr", int'(fb_wr), 0);
    chk("abort busy", int'(busy), 0);
    blit_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    chk("abort pending_writes", wq.size(), 0);
    fb_cmp("abort");
    repeat (2) @(negedge clk);

    v = '{BLIT_OP_SPRITE, 0, 12'h150, 4'd4, 7'd40, 6'd8, 0, 50};
    run_vec(v, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
